// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, WAIT)
//   arb_owner_t : which requester owns the outstanding transaction
//   ARB_CNT_W   : width of the latency and starvation counters
package mem_arb_pkg;

  localparam int ARB_CNT_W = 4;
  localparam logic [ARB_CNT_W-1:0] ARB_CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the fetch port has waited.
//   clk, rst  : clock, asynchronous active-low reset
//   waiting   : fetch request pending this cycle
//   granted   : fetch request accepted this cycle
//   count     : cycles waited so far, saturates at all-ones
//   at_limit  : count has reached LIMIT, fetch overrides data priority
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 waiting,
  input  logic                 granted,
  output logic [ARB_CNT_W-1:0] count,
  output logic                 at_limit
);

  localparam logic [ARB_CNT_W-1:0] LIMIT_C = LIMIT[ARB_CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!waiting || granted) begin
      count <= '0;
    end else if (count != ARB_CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count >= LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between the fetch
// (I) port and the data (D) port, one transaction at a time, and routes
// each response back to the port that issued it.
//   clk, rst                   : clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt         : fetch request, address, accept strobe
//   i_rvalid/i_rdata           : fetch response pulse and data
//   d_req/d_we/d_be/d_addr/
//   d_wdata/d_gnt              : data request (load/store) and accept strobe
//   d_rvalid/d_rdata           : load data or store ack pulse, load data
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata         : memory issue interface
//   mem_rdata                  : memory read data, valid MEM_LATENCY after issue
//   busy                       : FSM state (high in WAIT), transaction outstanding
//
// Handshake: a requester raises x_req and holds it with stable attributes
// until x_gnt; the transfer happens in the cycle where x_req && x_gnt.
// Dropping x_req before x_gnt withdraws the request. Exactly one x_rvalid
// pulse follows each transfer, MEM_LATENCY cycles after the grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int RELOAD_I = MEM_LATENCY - 1;
  localparam logic [ARB_CNT_W-1:0] CNT_RELOAD = RELOAD_I[ARB_CNT_W-1:0];

  arb_state_t           state, state_d;
  arb_owner_t           owner, owner_d;
  logic [ARB_CNT_W-1:0] cnt, cnt_d;
  logic [ARB_CNT_W-1:0] scnt;
  logic                 starve_at_limit;
  logic                 resp, grant_opp, d_win, i_win;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .waiting  (i_req),
    .granted  (i_win),
    .count    (scnt),
    .at_limit (starve_at_limit)
  );

  // The response cycle doubles as a grant opportunity so back-to-back
  // transactions sustain one per MEM_LATENCY cycles.
  always_comb begin
    resp      = (state == WAIT) && (cnt == '0);
    grant_opp = (state == IDLE) || resp;
    d_win     = grant_opp && d_req && !(i_req && starve_at_limit);
    i_win     = grant_opp && i_req && !d_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_I;
      cnt   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    if (d_win || i_win) begin
      state_d = WAIT;
      cnt_d   = CNT_RELOAD;
      owner_d = d_win ? OWN_D : OWN_I;
    end else if (resp) begin
      state_d = IDLE;
    end else if (state == WAIT) begin
      cnt_d = cnt - 1'b1;
    end
  end

  // Grant and issue outputs. They are forced low while rst is asserted so a
  // request held through reset does not show a phantom grant.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (d_win) begin
        d_gnt     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (i_win) begin
        i_gnt    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = i_addr;
      end
    end
  end

  always_comb begin
    i_rvalid = resp && (owner == OWN_I);
    d_rvalid = resp && (owner == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    busy     = (state == WAIT);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a runs MEM_LATENCY=2,
// STARVE_LIMIT=4; instance b runs MEM_LATENCY=1. Each has a small
// fixed-latency memory model. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance a signals
  logic        a_i_req, a_i_gnt, a_i_rvalid;
  logic [31:0] a_i_addr, a_i_rdata;
  logic        a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic [3:0]  a_d_be;
  logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
  logic        a_mem_req, a_mem_we, a_busy;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // instance b signals
  logic        b_i_req, b_i_gnt, b_i_rvalid;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_mem_req, b_mem_we, b_busy;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // memory model a: latency 2, preloaded while rst is low
  logic [31:0] mem_a [0:255];
  logic [31:0] pipe_a [0:1];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= 32'h0;
      mem_a[0] <= 32'h00500093;
      mem_a[1] <= 32'hCAFEF00D;
      pipe_a[0] <= 32'h0;
      pipe_a[1] <= 32'h0;
    end else begin
      if (a_mem_req && a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem_a[a_mem_addr[9:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end
      pipe_a[0] <= a_mem_req ? mem_a[a_mem_addr[9:2]] : 32'h0;
      pipe_a[1] <= pipe_a[0];
    end
  end
  assign a_mem_rdata = pipe_a[1];

  // memory model b: latency 1
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem_b[k] <= 32'h0;
      mem_b[0] <= 32'h11111111;
      mem_b[1] <= 32'h22222222;
      mem_b[2] <= 32'h33333333;
      pipe_b <= 32'h0;
    end else begin
      if (b_mem_req && b_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b_mem_be[k]) mem_b[b_mem_addr[9:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
      end
      pipe_b <= b_mem_req ? mem_b[b_mem_addr[9:2]] : 32'h0;
    end
  end
  assign b_mem_rdata = pipe_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  logic [6:0] exp_dg, exp_ig, exp_dv, exp_iv;

  initial begin
    rst = 1'b0;
    a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = '0; a_d_addr = '0; a_d_wdata = '0;
    b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = '0; b_d_addr = '0; b_d_wdata = '0;

    // ---- reset: a request held during reset must not be granted
    a_i_req = 1'b1;
    a_d_req = 1'b1;
    tick(); tick();
    probe();
    check("rst_i_gnt", a_i_gnt, 1'b0);
    check("rst_d_gnt", a_d_gnt, 1'b0);
    check("rst_mem_req", a_mem_req, 1'b0);
    check("rst_mem_addr", a_mem_addr, 32'h0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_i_rvalid", a_i_rvalid, 1'b0);
    check("rst_d_rvalid", a_d_rvalid, 1'b0);
    tick();
    rst = 1'b1;
    a_i_req = 1'b0;
    a_d_req = 1'b0;
    tick();

    // ---- test 1: single fetch
    a_i_req = 1'b1; a_i_addr = 32'h0;
    probe();
    check("t1_c0_i_gnt", a_i_gnt, 1'b1);
    check("t1_c0_mem_req", a_mem_req, 1'b1);
    check("t1_c0_mem_addr", a_mem_addr, 32'h0);
    check("t1_c0_mem_we", a_mem_we, 1'b0);
    check("t1_c0_busy", a_busy, 1'b0);
    tick();
    a_i_req = 1'b0;
    probe();
    check("t1_c1_busy", a_busy, 1'b1);
    check("t1_c1_mem_req", a_mem_req, 1'b0);
    check("t1_c1_i_rvalid", a_i_rvalid, 1'b0);
    tick();
    probe();
    check("t1_c2_i_rvalid", a_i_rvalid, 1'b1);
    check("t1_c2_i_rdata", a_i_rdata, 32'h00500093);
    check("t1_c2_busy", a_busy, 1'b1);
    check("t1_c2_d_rvalid", a_d_rvalid, 1'b0);
    tick();
    probe();
    check("t1_c3_busy", a_busy, 1'b0);
    check("t1_c3_i_rvalid", a_i_rvalid, 1'b0);
    check("t1_c3_i_rdata", a_i_rdata, 32'h0);
    tick();

    // ---- test 2: simultaneous requests, D wins, I granted in D response cycle
    a_i_req = 1'b1; a_i_addr = 32'h4;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0;
    probe();
    check("t2_c0_d_gnt", a_d_gnt, 1'b1);
    check("t2_c0_i_gnt", a_i_gnt, 1'b0);
    tick();
    a_d_req = 1'b0;
    probe();
    check("t2_c1_i_gnt", a_i_gnt, 1'b0);
    tick();
    probe();
    check("t2_c2_d_rvalid", a_d_rvalid, 1'b1);
    check("t2_c2_d_rdata", a_d_rdata, 32'h00500093);
    check("t2_c2_i_gnt", a_i_gnt, 1'b1);
    check("t2_c2_mem_addr", a_mem_addr, 32'h4);
    tick();
    a_i_req = 1'b0;
    probe();
    check("t2_c3_i_rvalid", a_i_rvalid, 1'b0);
    tick();
    probe();
    check("t2_c4_i_rvalid", a_i_rvalid, 1'b1);
    check("t2_c4_i_rdata", a_i_rdata, 32'hCAFEF00D);
    check("t2_c4_d_rvalid", a_d_rvalid, 1'b0);
    tick();
    probe();
    check("t2_c5_busy", a_busy, 1'b0);
    tick();

    // ---- test 3: both held, starvation override at cycle 4
    exp_dg = 7'b1000101;
    exp_ig = 7'b0010000;
    exp_dv = 7'b0010100;
    exp_iv = 7'b1000000;
    a_i_req = 1'b1; a_i_addr = 32'h4;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0;
    for (int k = 0; k < 7; k++) begin
      probe();
      check($sformatf("t3_c%0d_d_gnt", k), a_d_gnt, exp_dg[k]);
      check($sformatf("t3_c%0d_i_gnt", k), a_i_gnt, exp_ig[k]);
      check($sformatf("t3_c%0d_d_rvalid", k), a_d_rvalid, exp_dv[k]);
      check($sformatf("t3_c%0d_i_rvalid", k), a_i_rvalid, exp_iv[k]);
      tick();
    end
    a_i_req = 1'b0;
    a_d_req = 1'b0;
    probe();
    check("t3_c6_i_rdata", a_i_rdata, 32'h0);
    check("t3_c7_busy", a_busy, 1'b1);
    tick();
    probe();
    check("t3_c8_d_rvalid", a_d_rvalid, 1'b1);
    check("t3_c8_d_rdata", a_d_rdata, 32'h00500093);
    tick();
    probe();
    check("t3_c9_busy", a_busy, 1'b0);
    tick();

    // ---- test 4: partial store then load back
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011; a_d_addr = 32'h100; a_d_wdata = 32'hDEADBEEF;
    probe();
    check("t4_st_d_gnt", a_d_gnt, 1'b1);
    check("t4_st_mem_we", a_mem_we, 1'b1);
    check("t4_st_mem_be", a_mem_be, 4'b0011);
    check("t4_st_mem_addr", a_mem_addr, 32'h100);
    check("t4_st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    tick();
    a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = 4'b0000; a_d_wdata = 32'h0;
    probe();
    check("t4_c1_d_rvalid", a_d_rvalid, 1'b0);
    tick();
    a_d_req = 1'b1;
    probe();
    check("t4_st_ack", a_d_rvalid, 1'b1);
    check("t4_ld_d_gnt", a_d_gnt, 1'b1);
    check("t4_ld_mem_we", a_mem_we, 1'b0);
    check("t4_ld_mem_be", a_mem_be, 4'b0000);
    tick();
    a_d_req = 1'b0;
    tick();
    probe();
    check("t4_ld_d_rvalid", a_d_rvalid, 1'b1);
    check("t4_ld_d_rdata", a_d_rdata, 32'h0000BEEF);
    tick();
    tick();

    // ---- test 5: reset mid-transaction drops the response
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0;
    probe();
    check("t5_c0_d_gnt", a_d_gnt, 1'b1);
    tick();
    a_d_req = 1'b0;
    rst = 1'b0;
    probe();
    check("t5_rst_busy", a_busy, 1'b0);
    check("t5_rst_d_rvalid", a_d_rvalid, 1'b0);
    check("t5_rst_d_rdata", a_d_rdata, 32'h0);
    check("t5_rst_mem_req", a_mem_req, 1'b0);
    check("t5_rst_d_gnt", a_d_gnt, 1'b0);
    tick();
    probe();
    check("t5_c2_d_rvalid", a_d_rvalid, 1'b0);
    check("t5_c2_busy", a_busy, 1'b0);
    tick();
    rst = 1'b1;
    a_d_req = 1'b1; a_d_addr = 32'h4;
    probe();
    check("t5_rel_d_gnt", a_d_gnt, 1'b1);
    check("t5_rel_mem_addr", a_mem_addr, 32'h4);
    tick();
    a_d_req = 1'b0;
    probe();
    check("t5_c4_d_rvalid", a_d_rvalid, 1'b0);
    tick();
    probe();
    check("t5_c5_d_rvalid", a_d_rvalid, 1'b1);
    check("t5_c5_d_rdata", a_d_rdata, 32'hCAFEF00D);
    tick();

    // ---- test 6: MEM_LATENCY=1 back-to-back loads
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h0;
    probe();
    check("t6_c0_d_gnt", b_d_gnt, 1'b1);
    check("t6_c0_mem_addr", b_mem_addr, 32'h0);
    check("t6_c0_d_rvalid", b_d_rvalid, 1'b0);
    tick();
    b_d_addr = 32'h4;
    probe();
    check("t6_c1_d_gnt", b_d_gnt, 1'b1);
    check("t6_c1_mem_addr", b_mem_addr, 32'h4);
    check("t6_c1_d_rvalid", b_d_rvalid, 1'b1);
    check("t6_c1_d_rdata", b_d_rdata, 32'h11111111);
    tick();
    b_d_addr = 32'h8;
    probe();
    check("t6_c2_d_gnt", b_d_gnt, 1'b1);
    check("t6_c2_mem_addr", b_mem_addr, 32'h8);
    check("t6_c2_d_rvalid", b_d_rvalid, 1'b1);
    check("t6_c2_d_rdata", b_d_rdata, 32'h22222222);
    tick();
    b_d_req = 1'b0;
    probe();
    check("t6_c3_d_gnt", b_d_gnt, 1'b0);
    check("t6_c3_d_rvalid", b_d_rvalid, 1'b1);
    check("t6_c3_d_rdata", b_d_rdata, 32'h33333333);
    tick();
    probe();
    check("t6_c4_busy", b_busy, 1'b0);
    check("t6_c4_d_rvalid", b_d_rvalid, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
